// File: rtl/shared_res_pkg.sv
// Shared definitions for the shared-resource arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE / BUSY)
//   clog2       : index-width helper, never returns less than 1
//   IDX_W       : requester index width for the default four-requester build
package shared_res_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    // A one-requester or one-count field still needs a physical bit.
    if (result < 1) result = 1;
    return result;
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int IDX_W       = clog2(DEF_NUM_REQ);

endpackage

// File: rtl/shared_resource_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     in  N   request vector
//   start   in  IW  index searched first; search wraps upward from here
//   excl    in  N   requesters that may not win this search
//   winner  out N   one-hot winner (zero when nothing eligible)
//   win_idx out IW  binary index of winner
//   found   out 1   an eligible requester exists
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] win_idx,
  output logic          found
);

  logic [N-1:0] elig;

  assign elig = req & ~excl;

  // Walk offsets from farthest to nearest so the nearest eligible
  // requester at or after start is the last assignment and wins.
  always_comb begin
    int j;
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start) + k) % N;
      if (elig[j]) begin
        winner    = '0;
        winner[j] = 1'b1;
        win_idx   = IW'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_resource_arbiter.sv
// Shares one fixed-latency pipelined resource among NUM_REQ requesters.
// Round-robin grant with a bounded number of consecutive issues per grant,
// combinational issue mux from the registered grant, and a tag delay line
// that routes each result back to the requester that issued it.
//   clk          in  clock
//   reset_n      in  asynchronous active-low reset
//   req          in  NUM_REQ         per-requester request
//   req_data     in  NUM_REQ*DATA_W  per-requester operand, slice i = requester i
//   grant        out NUM_REQ         registered one-hot (or zero) grant
//   res_in       out DATA_W          operand to resource
//   res_in_valid out 1               operand valid to resource
//   res_out      in  DATA_W          resource result, RES_LATENCY cycles after issue
//   rsp_data     out DATA_W          result bus shared by all requesters
//   rsp_valid    out NUM_REQ         one-hot owner of rsp_data this cycle
module shared_resource_arbiter
  import shared_res_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int RES_LATENCY = 2,
  parameter int MAX_HOLD    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         res_in,
  output logic                      res_in_valid,
  input  logic [DATA_W-1:0]         res_out,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid
);

  localparam int PTR_W  = clog2(NUM_REQ);
  localparam int HOLD_W = clog2(MAX_HOLD);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  // Return-path tags: valid bit and owner index per resource stage.
  logic [RES_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0]       tag_idx_q [RES_LATENCY];
  logic [PTR_W-1:0]       tag_idx_d [RES_LATENCY];

  logic [PTR_W-1:0]   owner_inc;
  logic               owner_req;
  logic               issue;
  logic               release_grant;
  logic [PTR_W-1:0]   pick_start;
  logic [NUM_REQ-1:0] pick_excl;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_found;

  assign owner_inc = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_req = req[owner_q];
  assign issue     = (state_q == BUSY) && owner_req;
  // Release on a dropped request, or on the issue that exhausts the hold budget.
  assign release_grant = (state_q == BUSY) &&
                         (!owner_req || (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)));

  // One picker serves both states: from IDLE it searches from rr_ptr with
  // nothing excluded; on release it searches from owner+1 excluding the owner
  // (owner+1 is exactly the pointer value being written on release).
  assign pick_start = (state_q == BUSY) ? owner_inc : rr_ptr_q;
  assign pick_excl  = (state_q == BUSY) ? grant_q   : '0;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (PTR_W)
  ) u_rr_pick (
    .req     (req),
    .start   (pick_start),
    .excl    (pick_excl),
    .winner  (pick_onehot),
    .win_idx (pick_idx),
    .found   (pick_found)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      tag_vld_q  <= '0;
      for (int k = 0; k < RES_LATENCY; k++) tag_idx_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      tag_vld_q  <= tag_vld_d;
      for (int k = 0; k < RES_LATENCY; k++) tag_idx_q[k] <= tag_idx_d[k];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BUSY;
          grant_d    = pick_onehot;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
        end
      end
      BUSY: begin
        if (issue) hold_cnt_d = hold_cnt_q + 1'b1;
        if (release_grant) begin
          rr_ptr_d = owner_inc;
          if (pick_found) begin
            grant_d    = pick_onehot;
            owner_d    = pick_idx;
            hold_cnt_d = '0;
          end else if (owner_req) begin
            // Hold expired but nobody else wants the resource: fresh grant.
            hold_cnt_d = '0;
          end else begin
            state_d    = IDLE;
            grant_d    = '0;
            hold_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Tag delay line: stage 0 captures the current issue and its owner.
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = issue;
    tag_idx_d[0] = owner_q;
    for (int k = 1; k < RES_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
  end

  // Outputs.
  always_comb begin
    grant        = grant_q;
    res_in_valid = issue;
    res_in       = '0;
    rsp_valid    = '0;
    rsp_data     = '0;
    if (issue) res_in = req_data[int'(owner_q)*DATA_W +: DATA_W];
    if (tag_vld_q[RES_LATENCY-1]) begin
      rsp_valid[tag_idx_q[RES_LATENCY-1]] = 1'b1;
      rsp_data                            = res_out;
    end
  end

endmodule

// File: tb/tb_shared_resource_arbiter.sv
module tb_shared_resource_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int MH  = 4;

  logic           clk      = 1'b0;
  logic           reset_n  = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   grant;
  logic [W-1:0]   res_in;
  logic           res_in_valid;
  logic [W-1:0]   res_out;
  logic [W-1:0]   rsp_data;
  logic [N-1:0]   rsp_valid;

  always #5 clk = ~clk;

  shared_resource_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (W),
    .RES_LATENCY (LAT),
    .MAX_HOLD    (MH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .res_in       (res_in),
    .res_in_valid (res_in_valid),
    .res_out      (res_out),
    .rsp_data     (rsp_data),
    .rsp_valid    (rsp_valid)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Resource stand-in: fixed transform, fixed latency, junk when idle.
  function automatic logic [W-1:0] resource_fn(input logic [W-1:0] x);
    return {x[15:0], x[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  logic [W-1:0] rpipe [LAT];
  always @(posedge clk) begin
    rpipe[0] <= res_in_valid ? resource_fn(res_in) : W'($urandom);
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign res_out = rpipe[LAT-1];

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    int           due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] one;
    one = 1;
    return (idx >= 0) ? (one << idx) : '0;
  endfunction

  // Reference model: owner (-1 = none), issues under current grant, rr pointer.
  int m_owner = -1;
  int m_hold  = 0;
  int m_rr    = 0;

  function automatic int first_from(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r);
    if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = first_from(r, m_rr, -1);
        m_hold  = 0;
      end
    end else begin
      bit iss, rel;
      int w;
      iss = r[m_owner];
      rel = !iss || (m_hold == MH - 1);
      if (iss) m_hold++;
      if (rel) begin
        m_rr = (m_owner + 1) % N;
        w    = first_from(r, m_rr, m_owner);
        if (w >= 0) begin
          m_owner = w;
          m_hold  = 0;
        end else if (iss) begin
          m_hold = 0;
        end else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end
    end
  endtask

  // One clock of stimulus: apply req, check the issue side, predict the response.
  task automatic drive_cycle(input logic [N-1:0] r);
    logic iss;
    logic [W-1:0] opnd;
    @(negedge clk);
    req = r;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
    #1;
    check("grant", W'(grant), W'(onehot(m_owner)));
    iss  = (m_owner >= 0) && r[m_owner];
    opnd = iss ? req_data[m_owner*W +: W] : '0;
    check("res_in_valid", W'(res_in_valid), W'(iss));
    check("res_in", res_in, opnd);
    if (iss) sb.push_back('{m_owner, resource_fn(opnd), cyc + LAT});
    model_step(r);
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", W'(grant), '0);
    check("rst_res_in_valid", W'(res_in_valid), '0);
    check("rst_res_in", res_in, '0);
    check("rst_rsp_valid", W'(rsp_valid), '0);
    check("rst_rsp_data", rsp_data, '0);
  endtask

  // Asynchronous reset in mid-cycle; in-flight results must be dropped.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    req     = N'($urandom);
    #1;
    check_reset_outputs();
    m_owner = -1;
    m_hold  = 0;
    m_rr    = 0;
    sb.delete();
    repeat (cycles) @(negedge clk);
    #1;
    check_reset_outputs();
    req     = '0;
    reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  exp_t e;
  always @(negedge clk) begin
    #2;
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rsp_unexpected cycle %0d: got rsp_valid %b expected none", cyc, rsp_valid);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", W'(rsp_valid), W'(onehot(e.idx)));
        check("rsp_data", rsp_data, e.data);
        check("rsp_cycle", W'(cyc), W'(e.due));
        check("rsp_eq_res_out", rsp_data, res_out);
      end
    end else begin
      check("rsp_data_idle", rsp_data, '0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        compared++;
        mismatched++;
        $display("FAIL rsp_missing cycle %0d: got no rsp_valid expected owner %0d due %0d",
                 cyc, e.idx, e.due);
      end
    end
  end

  logic [N-1:0] cur;

  initial begin
    reset_n = 1'b0;
    req     = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester held: continuous grant, re-grant on hold expiry.
    repeat (11) drive_cycle(4'b0001);
    repeat (3)  drive_cycle(4'b0000);
    // All requesting: four issues each, rotating with no gaps.
    repeat (20) drive_cycle(4'b1111);
    repeat (3)  drive_cycle(4'b0000);
    // Owner 2 drops after two issues while 0 and 3 wait: 3 goes next.
    repeat (3)  drive_cycle(4'b0100);
    repeat (8)  drive_cycle(4'b1001);
    repeat (3)  drive_cycle(4'b0000);
    // Back-to-back owners 1 then 2.
    repeat (2)  drive_cycle(4'b0010);
    repeat (2)  drive_cycle(4'b0100);
    repeat (3)  drive_cycle(4'b0000);
    // One-cycle pulse: granted once, never issues.
    drive_cycle(4'b0010);
    repeat (3)  drive_cycle(4'b0000);
    // Reset while results are in flight.
    repeat (3)  drive_cycle(4'b0001);
    do_reset(2);
    repeat (5)  drive_cycle(4'b0000);

    // Randomized traffic with sticky requests and a mid-run reset.
    cur = '0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1);
      if ($urandom_range(0, 3) == 0) cur = N'($urandom);
      drive_cycle(cur);
    end

    repeat (LAT + 3) drive_cycle(4'b0000);
    check("drain_pending", W'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
